// File: rtl/uart_rx_deframer_if.sv
// Received-byte stream between the UART deframer and the bus-side RX FIFO.
// valid holds with a stable payload until valid && ready.
interface uart_rx_deframer_if;
   logic       valid;
   logic       ready;
   logic [7:0] payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART RX deframer: 8x oversampling, 3-sample majority vote, start/data/parity/stop FSM.
// Byte valid 1 clk after final stop decision; 1-deep buffer, a full unread buffer drops the new byte with an overrun pulse.
module uart_rx_deframer #(
   parameter int CLK_DIV_WIDTH = 20,
   parameter int DATA_BITS     = 8
) (
   input  logic                     io_mainClk,
   input  logic                     resetCtrl_systemReset_n,
   input  logic                     io_rxd,
   input  logic [CLK_DIV_WIDTH-1:0] io_cfg_clockDivider,
   input  logic [1:0]               io_cfg_parity,
   input  logic                     io_cfg_stopBits,
   uart_rx_deframer_if.master       io_read,
   output logic                     io_frameError,
   output logic                     io_parityError,
   output logic                     io_overrun
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   state_t                   state;
   state_t                   stateNext;
   logic [CLK_DIV_WIDTH-1:0] tickCnt;
   logic                     tick;
   logic [1:0]               samples;
   logic [2:0]               phase;
   logic [2:0]               tickPhase;
   logic [2:0]               bitCnt;
   logic [7:0]               shiftReg;
   logic                     parityFlag;
   logic                     stopCnt;
   logic                     bitVal;
   logic                     decide;
   logic                     phaseEnd;
   logic                     parityEn;
   logic                     parityBad;
   logic                     frameErrSet;
   logic                     parityErrSet;
   logic                     deliver;

   assign tick      = (tickCnt == '0);
   assign tickPhase = phase + 3'd1;
   // samples[1], samples[0] hold the phase-3 and phase-4 samples; io_rxd is the phase-5 sample
   assign bitVal    = (samples[1] & samples[0]) | (samples[1] & io_rxd) | (samples[0] & io_rxd);
   assign decide    = tick && (state != IDLE) && (tickPhase == 3'd5);
   assign phaseEnd  = tick && (state != IDLE) && (tickPhase == 3'd7);
   assign parityEn  = (io_cfg_parity == 2'd1) || (io_cfg_parity == 2'd2);
   assign parityBad = bitVal ^ (^shiftReg) ^ io_cfg_parity[1];

   always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
      if (!resetCtrl_systemReset_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext    = state;
      frameErrSet  = 1'b0;
      parityErrSet = 1'b0;
      deliver      = 1'b0;
      case (state)
         IDLE: begin
            if (tick && !io_rxd) stateNext = START;
         end
         START: begin
            if (decide && bitVal) stateNext = IDLE;
            else if (phaseEnd)    stateNext = DATA;
         end
         DATA: begin
            if (phaseEnd && (bitCnt == LAST_BIT)) stateNext = parityEn ? PARITY : STOP;
         end
         PARITY: begin
            if (phaseEnd) stateNext = STOP;
         end
         STOP: begin
            if (decide) begin
               if (!bitVal) begin
                  frameErrSet = 1'b1;
                  stateNext   = IDLE;
               end else if (!(io_cfg_stopBits && !stopCnt)) begin
                  parityErrSet = parityFlag;
                  deliver      = !parityFlag;
                  stateNext    = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
      if (!resetCtrl_systemReset_n) begin
         tickCnt    <= '0;
         samples    <= '0;
         phase      <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         parityFlag <= 1'b0;
         stopCnt    <= 1'b0;
      end else begin
         tickCnt <= tick ? io_cfg_clockDivider : tickCnt - {{(CLK_DIV_WIDTH-1){1'b0}}, 1'b1};
         if (tick) samples <= {samples[0], io_rxd};
         if (state == IDLE)  phase <= '0;
         else if (tick)      phase <= tickPhase;
         if (state == START && phaseEnd) begin
            bitCnt     <= '0;
            shiftReg   <= '0;
            parityFlag <= 1'b0;
         end
         if (state == DATA && decide)   shiftReg[bitCnt] <= bitVal;
         if (state == DATA && phaseEnd) bitCnt <= bitCnt + 3'd1;
         if (state == PARITY && decide) parityFlag <= parityBad;
         if (state != STOP)  stopCnt <= 1'b0;
         else if (decide)    stopCnt <= 1'b1;
      end
   end

   always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
      if (!resetCtrl_systemReset_n) begin
         io_read.valid   <= 1'b0;
         io_read.payload <= '0;
         io_frameError   <= 1'b0;
         io_parityError  <= 1'b0;
         io_overrun      <= 1'b0;
      end else begin
         io_frameError  <= frameErrSet;
         io_parityError <= parityErrSet;
         io_overrun     <= deliver && io_read.valid && !io_read.ready;
         // a read in the delivery cycle frees the slot for the new byte
         if (deliver && (!io_read.valid || io_read.ready)) begin
            io_read.valid   <= 1'b1;
            io_read.payload <= shiftReg;
         end else if (io_read.valid && io_read.ready) begin
            io_read.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed frames at divider 4 (40 clk/bit); frame-level outcome model plus per-cycle stream/pulse checker.
module tb_uart_rx_deframer;
   logic        io_mainClk = 1'b0;
   logic        rstN       = 1'b1;
   logic        rxd        = 1'b1;
   logic [19:0] clkDiv     = 20'd4;
   logic [1:0]  parityCfg  = 2'd0;
   logic        stopCfg    = 1'b0;
   logic        frameErr;
   logic        parityErr;
   logic        overrun;

   uart_rx_deframer_if rdIf ();

   always #5 io_mainClk = ~io_mainClk;

   uart_rx_deframer #(.CLK_DIV_WIDTH(20), .DATA_BITS(8)) dut (
      .io_mainClk              (io_mainClk),
      .resetCtrl_systemReset_n (rstN),
      .io_rxd                  (rxd),
      .io_cfg_clockDivider     (clkDiv),
      .io_cfg_parity           (parityCfg),
      .io_cfg_stopBits         (stopCfg),
      .io_read                 (rdIf.master),
      .io_frameError           (frameErr),
      .io_parityError          (parityErr),
      .io_overrun              (overrun)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] expQ [$];
   int   pendFerr = 0, pendPerr = 0, pendOvr = 0;
   int   ferrCount = 0, perrCount = 0, ovrCount = 0, readCount = 0;
   logic [7:0] lastRead = 8'h00;
   int   posCount = 0, frameStartPos = 0, latLo = 0, latHi = 0;
   bit   latPending = 1'b0;
   logic prevValid = 1'b0, prevHs = 1'b0, prevFerr = 1'b0, prevPerr = 1'b0, prevOvr = 1'b0;
   logic [7:0] prevPayload = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge io_mainClk) posCount++;

   always @(negedge io_mainClk) begin
      if (!rstN) begin
         prevValid = 1'b0; prevHs = 1'b0;
         prevFerr = 1'b0; prevPerr = 1'b0; prevOvr = 1'b0;
      end else begin
         if (frameErr) begin
            ferrCount++;
            check("frame_err_expected", pendFerr > 0, 1);
            check("frame_err_width", prevFerr, 0);
            if (pendFerr > 0) pendFerr--;
         end
         if (parityErr) begin
            perrCount++;
            check("parity_err_expected", pendPerr > 0, 1);
            check("parity_err_width", prevPerr, 0);
            if (pendPerr > 0) pendPerr--;
         end
         if (overrun) begin
            ovrCount++;
            check("overrun_expected", pendOvr > 0, 1);
            check("overrun_width", prevOvr, 0);
            if (pendOvr > 0) pendOvr--;
         end
         if (frameErr || parityErr || overrun)
            check("pulse_exclusive", $countones({frameErr, parityErr, overrun}), 1);
         if (prevValid && !prevHs) begin
            check("valid_hold", rdIf.valid, 1);
            check("payload_hold", rdIf.payload, prevPayload);
         end
         if (prevHs) check("valid_clear", rdIf.valid, 0);
         if (rdIf.valid && !prevValid) begin
            check("valid_rise_expected", expQ.size() > 0, 1);
            if (latPending) begin
               check("latency_window", (posCount - frameStartPos >= latLo) &&
                                       (posCount - frameStartPos <= latHi), 1);
               latPending = 1'b0;
            end
         end
         if (rdIf.valid && rdIf.ready) begin
            check("transfer_expected", expQ.size() > 0, 1);
            if (expQ.size() > 0) check("payload", rdIf.payload, expQ.pop_front());
            lastRead = rdIf.payload;
            readCount++;
         end
         prevValid   = rdIf.valid;
         prevHs      = rdIf.valid && rdIf.ready;
         prevPayload = rdIf.payload;
         prevFerr    = frameErr;
         prevPerr    = parityErr;
         prevOvr     = overrun;
      end
   end

   // Model: decide the frame's outcome from the bits sent, then drive it onto rxd.
   task automatic sendFrame(input logic [7:0] data, input bit flipParity, input bit stopLevel);
      bit   parEn;
      logic parBit;
      int   extraBits;
      parEn     = (parityCfg == 2'd1) || (parityCfg == 2'd2);
      parBit    = (^data) ^ parityCfg[1] ^ flipParity;
      extraBits = (parEn ? 1 : 0) + (stopCfg ? 1 : 0);
      if (!stopLevel)                          pendFerr++;
      else if (parEn && flipParity)            pendPerr++;
      else if (expQ.size() > 0 && !rdIf.ready) pendOvr++;
      else begin
         expQ.push_back(data);
         latLo      = 386 + 40 * extraBits;
         latHi      = latLo + 4;
         latPending = 1'b1;
      end
      @(negedge io_mainClk);
      rxd = 1'b0;
      frameStartPos = posCount;
      repeat (40) @(negedge io_mainClk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (40) @(negedge io_mainClk);
      end
      if (parEn) begin
         rxd = parBit;
         repeat (40) @(negedge io_mainClk);
      end
      rxd = stopLevel;
      repeat (40) @(negedge io_mainClk);
      if (stopCfg && stopLevel) begin
         rxd = 1'b1;
         repeat (40) @(negedge io_mainClk);
      end
      rxd = 1'b1;
      repeat (120) @(negedge io_mainClk);
      check("frame_err_seen", pendFerr, 0);
      check("parity_err_seen", pendPerr, 0);
      check("overrun_seen", pendOvr, 0);
      check("delivery_seen", latPending, 0);
   endtask

   initial begin
      logic [7:0] abortByte;
      abortByte = 8'h7E;
      rdIf.ready = 1'b1;
      #2 rstN = 1'b0;
      repeat (3) @(negedge io_mainClk);
      check("rst_valid", rdIf.valid, 0);
      check("rst_payload", rdIf.payload, 0);
      check("rst_pulses", {frameErr, parityErr, overrun}, 0);
      @(posedge io_mainClk); #2 rstN = 1'b1;
      repeat (20) @(negedge io_mainClk);

      sendFrame(8'hA5, 1'b0, 1'b1);
      check("lit_a5", lastRead, 8'hA5);
      check("lit_a5_count", readCount, 1);
      check("lit_a5_no_pulse", ferrCount + perrCount + ovrCount, 0);

      parityCfg = 2'd1;
      sendFrame(8'h03, 1'b1, 1'b1);
      check("lit_perr_count", perrCount, 1);
      check("lit_perr_no_read", readCount, 1);
      sendFrame(8'h03, 1'b0, 1'b1);
      check("lit_03", lastRead, 8'h03);
      check("lit_03_count", readCount, 2);

      parityCfg = 2'd0;
      sendFrame(8'h55, 1'b0, 1'b0);
      check("lit_ferr_count", ferrCount, 1);
      check("lit_ferr_no_read", readCount, 2);
      sendFrame(8'h12, 1'b0, 1'b1);
      check("lit_12", lastRead, 8'h12);

      parityCfg = 2'd2; stopCfg = 1'b1;
      sendFrame(8'h3C, 1'b0, 1'b1);
      check("lit_3c_8o2", lastRead, 8'h3C);
      parityCfg = 2'd0; stopCfg = 1'b0;

      @(posedge io_mainClk); #1 rdIf.ready = 1'b0;
      sendFrame(8'h11, 1'b0, 1'b1);
      sendFrame(8'h22, 1'b0, 1'b1);
      check("lit_ovr_count", ovrCount, 1);
      check("lit_ovr_valid", rdIf.valid, 1);
      check("lit_ovr_keep_11", rdIf.payload, 8'h11);
      check("lit_ovr_no_read", readCount, 4);
      @(posedge io_mainClk); #1 rdIf.ready = 1'b1;
      repeat (10) @(negedge io_mainClk);
      check("lit_ovr_read_11", lastRead, 8'h11);
      check("lit_ovr_one_xfer", readCount, 5);

      @(negedge io_mainClk); rxd = 1'b0;
      repeat (16) @(negedge io_mainClk);
      rxd = 1'b1;
      repeat (150) @(negedge io_mainClk);
      check("lit_glitch_no_read", readCount, 5);
      check("lit_glitch_no_pulse", ferrCount + perrCount + ovrCount, 3);
      check("lit_glitch_valid", rdIf.valid, 0);

      @(posedge io_mainClk); #1 rdIf.ready = 1'b0;
      sendFrame(8'h5A, 1'b0, 1'b1);
      check("lit_5a_held", rdIf.payload, 8'h5A);
      @(negedge io_mainClk); rxd = 1'b0;
      repeat (40) @(negedge io_mainClk);
      for (int i = 0; i < 3; i++) begin
         rxd = abortByte[i];
         repeat (40) @(negedge io_mainClk);
      end
      rxd = abortByte[3];
      repeat (20) @(negedge io_mainClk);
      @(posedge io_mainClk); #2 rstN = 1'b0;
      #1;
      check("rst_mid_valid", rdIf.valid, 0);
      check("rst_mid_payload", rdIf.payload, 0);
      check("rst_mid_pulses", {frameErr, parityErr, overrun}, 0);
      expQ.delete();
      latPending = 1'b0;
      rxd = 1'b1;
      rdIf.ready = 1'b1;
      repeat (4) @(negedge io_mainClk);
      @(posedge io_mainClk); #2 rstN = 1'b1;
      repeat (20) @(negedge io_mainClk);
      sendFrame(8'h81, 1'b0, 1'b1);
      check("lit_81", lastRead, 8'h81);
      check("lit_81_count", readCount, 6);
      check("queue_drained", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
